// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | onehot_rr_arbiter: round-robin arbiter with offer/accept/release handshake |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module onehot_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               grant_valid_o,
  input  logic               grant_ready_i,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic [NUM_REQ-1:0] grant_oh_o,
  input  logic               release_i,
  output logic               busy_o
);

  localparam logic [IDX_W:0]   c_NUM_EXT = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_idx;
  logic [NUM_REQ-1:0]   r_oh;
  logic                 r_valid;
  logic                 r_busy;

  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_win;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [IDX_W-1:0]     w_next_ptr;

  // Rotate requests so the pointer position lands at bit 0, then pick the lowest set bit.
  assign w_req2 = {req_i, req_i};
  assign w_rot  = NUM_REQ'(w_req2 >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = IDX_W'(j);
      end
    end
  end

  // Map the rotated offset back to an absolute index, wrapping at NUM_REQ.
  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win      = (w_sum >= c_NUM_EXT) ? IDX_W'(w_sum - c_NUM_EXT) : w_sum[IDX_W-1:0];
  assign w_win_oh   = NUM_REQ'(1) << w_win;
  assign w_next_ptr = (r_idx == c_LAST) ? '0 : r_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_oh    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_i) begin
            r_idx   <= w_win;
            r_oh    <= w_win_oh;
            r_valid <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (grant_ready_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (release_i) begin
            r_ptr   <= w_next_ptr;
            r_oh    <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_oh    <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid_o = r_valid;
  assign busy_o        = r_busy;
  assign grant_idx_o   = r_idx;
  assign grant_oh_o    = r_oh;

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// Bench for onehot_rr_arbiter: NUM_REQ=4 and NUM_REQ=5 instances share stimulus
// and are compared every cycle against a state-level round-robin model.
module tb_onehot_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req = '0;
  logic       ready = 1'b0;
  logic       rel = 1'b0;

  logic       v4, b4, v5, b5;
  logic [1:0] idx4;
  logic [3:0] oh4;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.NUM_REQ(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_i(req[3:0]),
    .grant_valid_o(v4), .grant_ready_i(ready), .grant_idx_o(idx4),
    .grant_oh_o(oh4), .release_i(rel), .busy_o(b4)
  );

  onehot_rr_arbiter #(.NUM_REQ(5)) u_dut5 (
    .clk(clk), .rst(rst), .req_i(req),
    .grant_valid_o(v5), .grant_ready_i(ready), .grant_idx_o(idx5),
    .grant_oh_o(oh5), .release_i(rel), .busy_o(b5)
  );

  // Model: 0 = idle, 1 = grant offered, 2 = owned
  int nn[2]   = '{4, 5};
  int ms[2]   = '{0, 0};
  int mptr[2] = '{0, 0};
  int midx[2] = '{0, 0};

  function automatic int winner(input int n, input int p, input logic [4:0] r);
    for (int i = 0; i < n; i++) begin
      if (r[(p + i) % n]) return (p + i) % n;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        ms[d]   <= 0;
        mptr[d] <= 0;
        midx[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [4:0] r;
        int w;
        r = (d == 0) ? (req & 5'b01111) : req;
        w = winner(nn[d], mptr[d], r);
        if (ms[d] == 0) begin
          if (w >= 0) begin
            midx[d] <= w;
            ms[d]   <= 1;
          end
        end else if (ms[d] == 1) begin
          if (ready) ms[d] <= 2;
        end else begin
          if (rel) begin
            mptr[d] <= (midx[d] + 1) % nn[d];
            ms[d]   <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic v, input logic b, input int idx, input int oh);
    int eoh;
    eoh = (ms[d] != 0) ? (1 << midx[d]) : 0;
    chk($sformatf("m%0d.valid", d), int'(v), int'(ms[d] == 1));
    chk($sformatf("m%0d.busy", d), int'(b), int'(ms[d] == 2));
    chk($sformatf("m%0d.idx", d), idx, midx[d]);
    chk($sformatf("m%0d.oh", d), oh, eoh);
    chk($sformatf("a%0d.onehot0", d), int'($onehot0(oh)), 1);
    chk($sformatf("a%0d.valid_busy_excl", d), int'(v && b), 0);
    if (ms[d] != 0) chk($sformatf("a%0d.oh_matches_idx", d), oh, 1 << idx);
  endtask

  always @(posedge clk) begin
    #2;
    cmp_dut(0, v4, b4, int'(idx4), int'(oh4));
    cmp_dut(1, v5, b5, int'(idx5), int'(oh5));
  end

  // Full offer/accept/release cycle; d selects which instance's grant is pinned.
  task automatic grant(input logic [4:0] r, input int d, input int exp);
    req = r;
    @(negedge clk);
    chk("lit.valid", (d == 0) ? int'(v4) : int'(v5), 1);
    chk("lit.idx", (d == 0) ? int'(idx4) : int'(idx5), exp);
    chk("lit.oh", (d == 0) ? int'(oh4) : int'(oh5), 1 << exp);
    ready = 1'b1;
    @(negedge clk);
    chk("lit.busy", (d == 0) ? int'(b4) : int'(b5), 1);
    chk("lit.valid_in_busy", (d == 0) ? int'(v4) : int'(v5), 0);
    ready = 1'b0;
    rel   = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    chk("lit.idle_oh", (d == 0) ? int'(oh4) : int'(oh5), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", int'(v4), 0);
    chk("rst.busy", int'(b4), 0);
    chk("rst.idx", int'(idx4), 0);
    chk("rst.oh", int'(oh4), 0);

    // Lowest pending at/after ptr 0 is 1; afterwards ptr=2 so {0,3} picks 3.
    grant(5'b01010, 0, 1);
    grant(5'b01001, 0, 3);

    foreach (nn[i]) begin end
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) grant(5'b01111, 0, order[k]);
    end

    // Five-requester wrap: idx 4 then ptr returns to 0.
    grant(5'b10000, 1, 4);
    grant(5'b10001, 1, 0);

    // Stalled offer while requests vanish and release toggles.
    req = 5'b01000;
    @(negedge clk);
    chk("stall.idx0", int'(idx4), 3);
    req = '0;
    for (int i = 0; i < 10; i++) begin
      rel = i[0];
      @(negedge clk);
      chk("stall.valid", int'(v4), 1);
      chk("stall.idx", int'(idx4), 3);
      chk("stall.busy", int'(b4), 0);
    end
    rel   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    rel   = 1'b1;
    @(negedge clk);
    rel = 1'b0;

    // Reset while owned aborts immediately, then restarts from ptr 0.
    req = 5'b00100;
    @(negedge clk);
    chk("abort.offer_idx", int'(idx4), 2);
    ready = 1'b1;
    @(negedge clk);
    chk("abort.busy", int'(b4), 1);
    ready = 1'b0;
    rst   = 1'b1;
    #1;
    chk("abort.valid", int'(v4), 0);
    chk("abort.busy0", int'(b4), 0);
    chk("abort.idx", int'(idx4), 0);
    chk("abort.oh", int'(oh4), 0);
    chk("abort.oh5", int'(oh5), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart.valid", int'(v4), 1);
    chk("restart.idx", int'(idx4), 2);
    chk("restart.oh", int'(oh4), 4);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    rel   = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
